// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// Write-back controller for the 8-entry general-purpose register file.
// The file's single write port is shared between the ALU result path and
// the memory-load path. A round-robin pointer picks the winner when both
// request. The winner's destination and data are registered onto the write
// port one cycle later. A per-register pending-write scoreboard is also
// kept here for the issue logic's hazard stalls.
//
// Ports
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   alu_vld    ALU write-back request
//   alu_dst    ALU destination register
//   alu_data   ALU result
//   alu_rdy    ALU request accepted this cycle (combinational)
//   mem_vld    load write-back request
//   mem_dst    load destination register
//   mem_data   load data
//   mem_rdy    load request accepted this cycle (combinational)
//   hold       freeze write-back, no grants while high
//   claim_en   issue logic reserves a destination
//   claim_dst  register being reserved
//   WEN        register file write enable (registered)
//   WrtDst     register file write address (registered)
//   WriteData  register file write data (registered)
//   busy       pending-write scoreboard, one bit per register
//   claim_err  sticky, set when a claim hits an already-busy register
module regfile_wb_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              alu_vld,
    input  logic [2:0]        alu_dst,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_rdy,
    input  logic              mem_vld,
    input  logic [2:0]        mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_rdy,
    input  logic              hold,
    input  logic              claim_en,
    input  logic [2:0]        claim_dst,
    output logic              WEN,
    output logic [2:0]        WrtDst,
    output logic [DATA_W-1:0] WriteData,
    output logic [7:0]        busy,
    output logic              claim_err
);

    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_MEM = 1'b1
    } pri_t;

    pri_t       pri;
    logic       both_vld;
    logic       alu_win;
    logic       mem_win;
    logic [7:0] busy_nxt;

    // Arbitration: a lone requester always wins; under contention the
    // pointer decides.
    always_comb begin
        both_vld = alu_vld & mem_vld;
        alu_win  = alu_vld & (~mem_vld | (pri == PRI_ALU));
        mem_win  = mem_vld & (~alu_vld | (pri == PRI_MEM));
        alu_rdy  = alu_win & ~hold;
        mem_rdy  = mem_win & ~hold;
    end

    // Scoreboard: the completing write clears first, so a claim to the same
    // register on the same edge leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (WEN) begin
            busy_nxt[WrtDst] = 1'b0;
        end
        if (claim_en) begin
            busy_nxt[claim_dst] = 1'b1;
        end
    end

    // Write-port register stage
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WEN       <= 1'b0;
            WrtDst    <= '0;
            WriteData <= '0;
            pri       <= PRI_ALU;
            busy      <= '0;
            claim_err <= 1'b0;
        end else begin
            WEN <= alu_rdy | mem_rdy;
            if (alu_rdy) begin
                WrtDst    <= alu_dst;
                WriteData <= alu_data;
            end else if (mem_rdy) begin
                WrtDst    <= mem_dst;
                WriteData <= mem_data;
            end
            // A contested grant hands priority to the loser; hold blocks the
            // grant and therefore leaves the pointer alone.
            if (both_vld && !hold) begin
                pri <= (pri == PRI_ALU) ? PRI_MEM : PRI_ALU;
            end
            busy <= busy_nxt;
            // Error looks at the scoreboard as it stood before this edge.
            if (claim_en && busy[claim_dst]) begin
                claim_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        alu_vld;
    logic [2:0]  alu_dst;
    logic [15:0] alu_data;
    logic        alu_rdy;
    logic        mem_vld;
    logic [2:0]  mem_dst;
    logic [15:0] mem_data;
    logic        mem_rdy;
    logic        hold;
    logic        claim_en;
    logic [2:0]  claim_dst;
    logic        WEN;
    logic [2:0]  WrtDst;
    logic [15:0] WriteData;
    logic [7:0]  busy;
    logic        claim_err;

    int checks = 0;
    int errors = 0;

    regfile_wb_ctrl #(.DATA_W(16)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .alu_vld   (alu_vld),
        .alu_dst   (alu_dst),
        .alu_data  (alu_data),
        .alu_rdy   (alu_rdy),
        .mem_vld   (mem_vld),
        .mem_dst   (mem_dst),
        .mem_data  (mem_data),
        .mem_rdy   (mem_rdy),
        .hold      (hold),
        .claim_en  (claim_en),
        .claim_dst (claim_dst),
        .WEN       (WEN),
        .WrtDst    (WrtDst),
        .WriteData (WriteData),
        .busy      (busy),
        .claim_err (claim_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N     = 1'b0;
        alu_vld   = 1'b1;
        alu_dst   = 3'd1;
        alu_data  = 16'h0001;
        mem_vld   = 1'b1;
        mem_dst   = 3'd2;
        mem_data  = 16'h0002;
        hold      = 1'b0;
        claim_en  = 1'b0;
        claim_dst = 3'd0;

        // Reset with both requesters active
        repeat (2) @(posedge CLK);
        #1;
        check("rst_wen", WEN, 0);
        check("rst_busy", busy, 8'h00);
        check("rst_err", claim_err, 0);
        check("rst_dst", WrtDst, 0);
        check("rst_data", WriteData, 16'h0000);

        // Release reset, contention for 4 cycles: ALU, MEM, ALU, MEM
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge CLK);
            #1;
            check($sformatf("cont%0d_alu_rdy", k), alu_rdy, (k % 2 == 0) ? 1 : 0);
            check($sformatf("cont%0d_mem_rdy", k), mem_rdy, (k % 2 == 0) ? 0 : 1);
            after_edge();
            check($sformatf("cont%0d_wen", k), WEN, 1);
            check($sformatf("cont%0d_dst", k), WrtDst, (k % 2 == 0) ? 1 : 2);
            check($sformatf("cont%0d_data", k), WriteData, (k % 2 == 0) ? 16'h0001 : 16'h0002);
        end
        @(negedge CLK);
        alu_vld = 1'b0;
        mem_vld = 1'b0;
        after_edge();
        check("cont_end_wen", WEN, 0);
        check("cont_end_dst", WrtDst, 2);

        // Single ALU write
        @(negedge CLK);
        alu_vld  = 1'b1;
        alu_dst  = 3'd3;
        alu_data = 16'hBEEF;
        #1;
        check("single_alu_rdy", alu_rdy, 1);
        check("single_mem_rdy", mem_rdy, 0);
        after_edge();
        check("single_wen", WEN, 1);
        check("single_dst", WrtDst, 3);
        check("single_data", WriteData, 16'hBEEF);
        @(negedge CLK);
        alu_vld = 1'b0;
        after_edge();
        check("single_wen_off", WEN, 0);
        check("single_dst_hold", WrtDst, 3);
        check("single_data_hold", WriteData, 16'hBEEF);

        // One contested grant to ALU moves priority to MEM, then hold
        @(negedge CLK);
        alu_vld  = 1'b1;
        alu_dst  = 3'd1;
        alu_data = 16'h0001;
        mem_vld  = 1'b1;
        #1;
        check("prehold_alu_rdy", alu_rdy, 1);
        after_edge();
        @(negedge CLK);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("hold%0d_alu_rdy", i), alu_rdy, 0);
            check($sformatf("hold%0d_mem_rdy", i), mem_rdy, 0);
            after_edge();
            check($sformatf("hold%0d_wen", i), WEN, 0);
            @(negedge CLK);
        end
        hold = 1'b0;
        #1;
        check("posthold_alu_rdy", alu_rdy, 0);
        check("posthold_mem_rdy", mem_rdy, 1);
        after_edge();
        check("posthold_wen", WEN, 1);
        check("posthold_dst", WrtDst, 2);
        @(negedge CLK);
        alu_vld = 1'b0;
        mem_vld = 1'b0;

        // Scoreboard: claim 5, then a load write to 5 clears it
        claim_en  = 1'b1;
        claim_dst = 3'd5;
        after_edge();
        check("claim5_busy", busy, 8'h20);
        check("claim5_err", claim_err, 0);
        @(negedge CLK);
        claim_en = 1'b0;
        mem_vld  = 1'b1;
        mem_dst  = 3'd5;
        mem_data = 16'h5555;
        #1;
        check("ld5_mem_rdy", mem_rdy, 1);
        after_edge();
        check("ld5_wen", WEN, 1);
        check("ld5_dst", WrtDst, 5);
        check("ld5_data", WriteData, 16'h5555);
        check("ld5_busy_still", busy, 8'h20);
        @(negedge CLK);
        mem_vld = 1'b0;
        after_edge();
        check("ld5_busy_clr", busy, 8'h00);
        check("ld5_wen_off", WEN, 0);

        // Claim 5, write 5, and re-claim 5 on the edge the write completes
        @(negedge CLK);
        claim_en  = 1'b1;
        claim_dst = 3'd5;
        after_edge();
        check("reclaim_busy", busy, 8'h20);
        @(negedge CLK);
        claim_en = 1'b0;
        mem_vld  = 1'b1;
        after_edge();
        check("wr5_wen", WEN, 1);
        @(negedge CLK);
        mem_vld  = 1'b0;
        claim_en = 1'b1;
        after_edge();
        check("collide_busy", busy, 8'h20);
        check("collide_err", claim_err, 1);
        @(negedge CLK);
        claim_en = 1'b0;
        after_edge();
        check("err_sticky", claim_err, 1);

        // Async reset between the accept edge and the write edge
        @(negedge CLK);
        alu_vld   = 1'b1;
        alu_dst   = 3'd6;
        alu_data  = 16'h6666;
        claim_en  = 1'b1;
        claim_dst = 3'd6;
        after_edge();
        check("arst_pre_wen", WEN, 1);
        check("arst_pre_busy", busy, 8'h60);
        #1;
        RST_N = 1'b0;
        #1;
        check("arst_wen", WEN, 0);
        check("arst_busy", busy, 8'h00);
        check("arst_err", claim_err, 0);
        check("arst_data", WriteData, 16'h0000);
        @(negedge CLK);
        alu_vld  = 1'b0;
        claim_en = 1'b0;
        RST_N    = 1'b1;
        after_edge();
        check("arst_no_write", WEN, 0);
        check("arst_busy_after", busy, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
